// File: rtl/vga_pkg.sv
// Shared timing defaults and colour helpers for the VGA scanout stage.
// Default timing is the 1220-wide 640x480@60 variant clocked at 48 MHz.
package vga_pkg;

  localparam int H_DISPLAY_D = 1220;
  localparam int H_FRONT_D   = 31;
  localparam int H_SYNC_D    = 183;
  localparam int H_BACK_D    = 92;
  localparam int V_DISPLAY_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;

  // 8x4 ordered-dither threshold; f0 flips the column phase
  function automatic logic [4:0] bayer5(
    input logic [2:0] h,
    input logic [1:0] v,
    input logic       f0
  );
    logic [2:0] bi;
    logic [2:0] bx;
    bi = h ^ {3{f0}};
    bx = {bi[2], bi[1] ^ v[1], bi[0] ^ v[0]};
    return {bx[0], bi[0], bx[1], bi[1], bx[2]};
  endfunction

  function automatic logic [3:0] dither(
    input logic [9:0] c,
    input logic [4:0] bayer,
    input int         cin,
    input int         cout
  );
    int t;
    t = int'(c) * ((1 << cout) - 1)
      + (int'(bayer) << (cin - 5));
    return 4'(t >> cin);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Generic shift register with synchronous clear to a fixed value.
// Depth 0 degenerates to a wire.
module vga_delay_line #(
  parameter int             W   = 8,
  parameter int             D   = 2,
  parameter logic [W-1:0]   CLR = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (D == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = clk ^ clr;
      assign q = d;
    end else begin : g_sr
      logic [W-1:0] sr [D];

      always_ff @(posedge clk) begin
        if (clr) begin
          for (int i = 0; i < D; i++)
            sr[i] <= CLR;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < D; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign q = sr[D-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scanout.sv
// VGA timing, frame counter and ordered-dither pin stage.
// VGA_SCANOUT_TEMPORAL_DITHER_EN: invert the Bayer column phase on odd frames.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_DISPLAY = H_DISPLAY_D,
  parameter int   H_FRONT   = H_FRONT_D,
  parameter int   H_SYNC    = H_SYNC_D,
  parameter int   H_BACK    = H_BACK_D,
  parameter int   V_DISPLAY = V_DISPLAY_D,
  parameter int   V_FRONT   = V_FRONT_D,
  parameter int   V_SYNC    = V_SYNC_D,
  parameter int   V_BACK    = V_BACK_D,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CIN       = 6,
  parameter int   COUT      = 2,
  parameter int   PIX_LAT   = 2
) (
  input  logic            clk48,
  input  logic            rst,
  input  logic [CIN-1:0]  pix_r,
  input  logic [CIN-1:0]  pix_g,
  input  logic [CIN-1:0]  pix_b,
  output logic [10:0]     h_count,
  output logic [9:0]      v_count,
  output logic [7:0]      frame,
  output logic            line_start,
  output logic            frame_start,
  output logic            hsync,
  output logic            vsync,
  output logic [COUT-1:0] r_out,
  output logic [COUT-1:0] g_out,
  output logic [COUT-1:0] b_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_DISPLAY);
  localparam logic [9:0]  V_ACT  = 10'(V_DISPLAY);
  localparam logic [10:0] HS_B   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_E   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_B   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_E   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
  localparam int BW = 9;
`else
  localparam int BW = 8;
`endif

  localparam logic [BW-1:0] CLR = {~HS_POL, ~VS_POL, {(BW-2){1'b0}}};

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;

  always_comb begin
    h_wrap = (h_count == H_LAST);
    v_wrap = (v_count == V_LAST);
    h_nxt  = h_wrap ? 11'd0 : h_count + 11'd1;
    v_nxt  = v_count;
    if (h_wrap)
      v_nxt = v_wrap ? 10'd0 : v_count + 10'd1;
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      frame       <= '0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      if (h_wrap && v_wrap)
        frame <= frame + 8'd1;
      line_start  <= (h_nxt == 11'd0);
      frame_start <= (h_nxt == 11'd0) && (v_nxt == 10'd0);
    end
  end

  logic          hs0;
  logic          vs0;
  logic          act0;
  logic [BW-1:0] s0;
  logic [BW-1:0] s1;

  always_comb begin
    hs0  = (h_count >= HS_B && h_count < HS_E) ? HS_POL : ~HS_POL;
    vs0  = (v_count >= VS_B && v_count < VS_E) ? VS_POL : ~VS_POL;
    act0 = (h_count < H_ACT) && (v_count < V_ACT);
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    s0 = {hs0, vs0, act0, h_count[2:0], v_count[1:0], frame[0]};
`else
    s0 = {hs0, vs0, act0, h_count[2:0], v_count[1:0]};
`endif
  end

  vga_delay_line #(
    .W   (BW),
    .D   (PIX_LAT),
    .CLR (CLR)
  ) u_dl (
    .clk (clk48),
    .clr (rst),
    .d   (s0),
    .q   (s1)
  );

  logic       hs1;
  logic       vs1;
  logic       act1;
  logic       f0;
  logic [4:0] bay;

  always_comb begin
    hs1  = s1[BW-1];
    vs1  = s1[BW-2];
    act1 = s1[BW-3];
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    f0   = s1[0];
`else
    f0   = 1'b0;
`endif
    bay  = bayer5(s1[BW-4 -: 3], s1[BW-7 -: 2], f0);
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
    end else begin
      hsync <= hs1;
      vsync <= vs1;
      r_out <= act1 ? COUT'(dither(10'(pix_r), bay, CIN, COUT)) : '0;
      g_out <= act1 ? COUT'(dither(10'(pix_g), bay, CIN, COUT)) : '0;
      b_out <= act1 ? COUT'(dither(10'(pix_b), bay, CIN, COUT)) : '0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken 24x12 raster,
// one DUT per source latency (0, 2, 8).
module tb_vga_scanout;

  localparam int HD = 16, HF = 2, HS = 4, HB = 2;
  localparam int VD = 8, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic clk48 = 1'b0;
  logic rst   = 1'b1;
  int   vec   = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk48 = ~clk48;
  always @(posedge clk48) cyc <= cyc + 1;

  typedef struct {
    int   due;
    int   h;
    int   v;
    int   f;
    logic ok;
  } ent_t;

  // hand-computed frame-0 pixels: r=h, g=42, b=21
  int th [5] = '{0, 1, 15, 5, 16};
  int tv [5] = '{0, 0, 3, 2, 0};
  int tr [5] = '{0, 0, 1, 1, 0};
  int tg [5] = '{1, 2, 2, 2, 0};
  int tb [5] = '{0, 1, 1, 1, 0};

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int pix_g_of(input int f);
    return (f % 3 == 0) ? 42 : ((f % 3 == 1) ? 0 : 63);
  endfunction

  function automatic int exp_bayer(input int h, input int v, input int f);
    int bi, bj, x0, x1, x2, f0;
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    f0 = f & 1;
`else
    f0 = 0;
`endif
    bi = (h & 7) ^ (f0 != 0 ? 7 : 0);
    bj = v & 3;
    x2 = (bi >> 2) & 1;
    x1 = ((bi >> 1) ^ (bj >> 1)) & 1;
    x0 = (bi ^ bj) & 1;
    return x0 * 16 + (bi & 1) * 8 + x1 * 4 + ((bi >> 1) & 1) * 2 + x2;
  endfunction

  function automatic int exp_dith(input int c, input int b);
    return (c * 3 + b * 2) / 64;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int L = (gi == 0) ? 0 : ((gi == 1) ? 2 : 8);

    logic [5:0]  pr, pg, pb;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [7:0]  fr;
    logic        ls, fs, hsy, vsy;
    logic [1:0]  ro, go, bo;

    ent_t pq [$];
    ent_t cq [$];
    ent_t hist [$];

    vga_scanout #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HS_POL(1'b0), .VS_POL(1'b0),
      .CIN(6), .COUT(2), .PIX_LAT(L)
    ) dut (
      .clk48(clk48), .rst(rst),
      .pix_r(pr), .pix_g(pg), .pix_b(pb),
      .h_count(hc), .v_count(vc), .frame(fr),
      .line_start(ls), .frame_start(fs),
      .hsync(hsy), .vsync(vsy),
      .r_out(ro), .g_out(go), .b_out(bo)
    );

    initial begin : drv
      int   h, v, f;
      ent_t c, e, z;
      h = 0; v = 0; f = 0;
      z.due = 0; z.h = 0; z.v = 0; z.f = 0; z.ok = 1'b0;
      pr = '0; pg = '0; pb = '0;
      forever begin
        @(posedge clk48);
        #1;
        if (rst) begin
          h = 0; v = 0; f = 0;
          hist.delete();
          for (int i = 0; i < L; i++) hist.push_back(z);
          if (pq.size() > 0 && pq[$].due == cyc) void'(pq.pop_back());
          e = z;
          e.due = cyc;
          pq.push_back(e);
        end else if (h == HT - 1) begin
          h = 0;
          if (v == VT - 1) begin
            v = 0;
            f = (f + 1) % 256;
          end else begin
            v = v + 1;
          end
        end else begin
          h = h + 1;
        end
        c.due = cyc; c.h = h; c.v = v; c.f = f; c.ok = 1'b1;
        cq.push_back(c);
        if (L == 0) begin
          e = c;
        end else begin
          hist.push_back(c);
          e = hist.pop_front();
        end
        if (e.ok && e.h < HD && e.v < VD) begin
          pr = 6'(e.h);
          pg = 6'(pix_g_of(e.f));
          pb = 6'd21;
        end else begin
          pr = 6'($urandom);
          pg = 6'($urandom);
          pb = 6'($urandom);
        end
        e.due = cyc + 1;
        pq.push_back(e);
      end
    end

    initial begin : mon
      ent_t e;
      int   xh, xv, xr, xg, xb, bay;
      logic act;
      forever begin
        @(posedge clk48);
        #2;
        if (cq.size() > 0 && cq[0].due == cyc) begin
          e = cq.pop_front();
          chk($sformatf("L%0d h_count", L), int'(hc), e.h);
          chk($sformatf("L%0d v_count", L), int'(vc), e.v);
          chk($sformatf("L%0d frame", L), int'(fr), e.f);
          chk($sformatf("L%0d line_start", L), int'(ls), int'(e.h == 0));
          chk($sformatf("L%0d frame_start", L), int'(fs),
              int'(e.h == 0 && e.v == 0));
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
          e = pq.pop_front();
          xh = 1; xv = 1; xr = 0; xg = 0; xb = 0;
          if (e.ok) begin
            act = (e.h < HD) && (e.v < VD);
            xh  = (e.h >= HD + HF && e.h < HD + HF + HS) ? 0 : 1;
            xv  = (e.v >= VD + VF && e.v < VD + VF + VS) ? 0 : 1;
            if (act) begin
              bay = exp_bayer(e.h, e.v, e.f);
              xr  = exp_dith(e.h & 63, bay);
              xg  = exp_dith(pix_g_of(e.f), bay);
              xb  = exp_dith(21, bay);
            end
          end
          chk($sformatf("L%0d hsync", L), int'(hsy), xh);
          chk($sformatf("L%0d vsync", L), int'(vsy), xv);
          chk($sformatf("L%0d r_out", L), int'(ro), xr);
          chk($sformatf("L%0d g_out", L), int'(go), xg);
          chk($sformatf("L%0d b_out", L), int'(bo), xb);
          if (e.ok && e.f == 0) begin
            for (int t = 0; t < 5; t++) begin
              if (e.h == th[t] && e.v == tv[t]) begin
                chk($sformatf("L%0d hand r(%0d,%0d)", L, e.h, e.v),
                    int'(ro), tr[t]);
                chk($sformatf("L%0d hand g(%0d,%0d)", L, e.h, e.v),
                    int'(go), tg[t]);
                chk($sformatf("L%0d hand b(%0d,%0d)", L, e.h, e.v),
                    int'(bo), tb[t]);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk48);
    rst = 1'b0;
    repeat (2 * HT * VT + 5 * HT + 10) @(negedge clk48);
    rst = 1'b1;
    @(negedge clk48);
    rst = 1'b0;
    repeat (2 * HT * VT) @(negedge clk48);
    repeat (2) @(negedge clk48);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
